ps2_mouse_packet: RTL and testbench
===================================

Name: ps2_mouse_packet

Overview:
Downstream consumer of the PS/2 mouse receive path. After the mouse init/command sequencer finishes, this block assembles the 3-byte stream-mode movement packets from the receiver's byte/tick output. It validates packet framing, decodes buttons and signed 9-bit deltas, and maintains a clamped absolute cursor position for display logic.

Parameters:
X_MAX, 639, maximum cursor x; x range is 0..X_MAX.
Y_MAX, 479, maximum cursor y; y range is 0..Y_MAX.
POS_W, 10, width of x_pos and y_pos.
X_INIT, 320, reset value of x_pos.
Y_INIT, 240, reset value of y_pos.
TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside one packet.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
en  in  1  high once the mouse init sequence reaches its done state; bytes are ignored while low
rx_done_tick  in  1  one-cycle pulse: rx_dout holds a received byte
rx_dout  in  8  received byte
pkt_valid  out  1  one-cycle pulse when a new packet is decoded
btn_l, btn_m, btn_r  out  1 each  button state from the last valid packet
dx  out  9  signed x delta from the last packet
dy  out  9  signed y delta from the last packet, PS/2 sense (up is positive)
x_pos  out  POS_W  cursor x
y_pos  out  POS_W  cursor y, screen sense (down is positive)
sync_err_count  out  8  saturating count of rejected byte0 candidates

Behaviour:
- Reset (rst=0, async): state=BYTE0, timeout counter=0, pkt_valid=0, buttons=0, dx=dy=0, x_pos=X_INIT, y_pos=Y_INIT, sync_err_count=0.
- FSM states: BYTE0, BYTE1, BYTE2. Transitions happen only on rx_done_tick with en=1.
- BYTE0 state: if rx_dout[3]=1, latch the byte and go to BYTE1. Otherwise discard it, stay in BYTE0 and increment sync_err_count, saturating at 255.
- BYTE1 state: latch the x byte and go to BYTE2.
- BYTE2 state: latch the y byte and go to BYTE0. On the next edge, pulse pkt_valid and update the button/delta outputs. Latency is 1 cycle from the byte2 tick.
- Decode from byte0 b:
  - btn_l=b[0], btn_r=b[1], btn_m=b[2].
  - dx={b[4],xbyte}; dy={b[5],ybyte}.
  - If the overflow bit (b[6] for x, b[7] for y) is set, that axis delta is reported as 0. Buttons are still updated.
- Cursor update, on the edge after pkt_valid (latency 2 from the byte2 tick):
  - x_pos <= clamp(x_pos+dx, 0, X_MAX).
  - y_pos <= clamp(y_pos-dy, 0, Y_MAX).
  - Compute in signed POS_W+2 bits; no wrap-around is allowed.
- Timeout: the counter runs while state≠BYTE0 and resets on every accepted byte. When it reaches TIMEOUT_CYCLES, the partial packet is discarded and the FSM returns to BYTE0 with no pkt_valid. If rx_done_tick coincides with expiry, the byte wins: it is accepted and the counter is cleared.
- en low: rx_done_tick is ignored. en falling mid-packet forces BYTE0 on the next edge and discards the partial packet. Outputs and position hold.
- Outputs are held between packets. Only pkt_valid pulses.
- Reset mid-packet: immediate return to all reset values. The next byte is treated as a byte0 candidate.

Decomposition:
- Package ps2_mouse_pkg:
  - pkt_state_t enum {BYTE0, BYTE1, BYTE2}.
  - mouse_pkt_t packed struct {btn_l, btn_m, btn_r, x_ovf, y_ovf, logic signed [8:0] dx, dy}.
  - Constant SYNC_BIT=3.
- One sub-module, ps2_cursor_accum: the signed add/subtract and clamp for both axes. Inputs are pkt_valid, dx and dy; it owns x_pos and y_pos.

Test Plan:
- en=1; bytes 0x09,0x05,0x03 -> pkt_valid 1 cycle after 3rd tick; btn_l=1; dx=+5; dy=+3; next cycle x_pos=325, y_pos=237.
- Bytes 0x38,0xFB,0xFE -> dx=-5, dy=-2, buttons 0; x_pos=315, y_pos=242 (from reset).
- Cursor at x=2: packet 0x18,0xF6,0x00 (dx=-10) -> x_pos=0. Cursor at y=Y_MAX: packet with dy=-20 -> y_pos=479. Neither axis wraps.
- Byte 0x00 in BYTE0 -> sync_err_count=1, no state change; a following valid packet decodes normally. Send 300 bad bytes -> count=255.
- Bytes 0x08,0x01, then idle TIMEOUT_CYCLES, then 0x08,0x02,0x03 -> exactly one pkt_valid, with dx=+2, dy=+3.
- Byte0 0x48 (x overflow) with xbyte 0x7F -> dx=0, x_pos unchanged. en dropped after byte1 -> no pkt_valid; assert rst low mid-packet -> x_pos=320, y_pos=240 immediately.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types for the PS/2 mouse packet assembler.
// Packet state, decoded packet bundle and header decode helper.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        BYTE0,
        BYTE1,
        BYTE2
    } pkt_state_t;

    typedef struct packed {
        logic              btn_l;
        logic              btn_m;
        logic              btn_r;
        logic              x_ovf;
        logic              y_ovf;
        logic signed [8:0] dx;
        logic signed [8:0] dy;
    } mouse_pkt_t;

    localparam int SYNC_BIT = 3;

    // Header byte carries buttons, overflow flags and the delta sign bits.
    function automatic mouse_pkt_t decode_hdr(input logic [7:0] b);
        mouse_pkt_t p;
        p.btn_l = b[0];
        p.btn_r = b[1];
        p.btn_m = b[2];
        p.x_ovf = b[6];
        p.y_ovf = b[7];
        p.dx    = {b[4], 8'h00};
        p.dy    = {b[5], 8'h00};
        return p;
    endfunction

endpackage

// File: rtl/ps2_cursor_accum.sv
// Absolute cursor position: adds packet deltas and clamps to the screen.
// y is screen sense, so the PS/2 up-positive dy is subtracted.
module ps2_cursor_accum #(
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479,
    parameter int POS_W  = 10,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    input  logic [8:0]       dx,
    input  logic [8:0]       dy,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos
);

    localparam int SW = POS_W + 2;
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

    logic [POS_W-1:0]     x_q, x_d;
    logic [POS_W-1:0]     y_q, y_d;
    logic signed [SW-1:0] xs, ys;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        xs  = $signed({2'b00, x_q}) + $signed({{(SW-9){dx[8]}}, dx});
        ys  = $signed({2'b00, y_q}) - $signed({{(SW-9){dy[8]}}, dy});
        if (pkt_valid) begin
            if (xs[SW-1])         x_d = '0;
            else if (xs > XMAX_S) x_d = POS_W'(X_MAX);
            else                  x_d = xs[POS_W-1:0];
            if (ys[SW-1])         y_d = '0;
            else if (ys > YMAX_S) y_d = POS_W'(Y_MAX);
            else                  y_d = ys[POS_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= POS_W'(X_INIT);
            y_q <= POS_W'(Y_INIT);
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 stream packets, decodes buttons/deltas and
// drives a clamped cursor position.
import ps2_mouse_pkg::*;

module ps2_mouse_packet #(
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int POS_W          = 10,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_dout,
    output logic             pkt_valid,
    output logic             btn_l,
    output logic             btn_m,
    output logic             btn_r,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic [7:0]       sync_err_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    pkt_state_t       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    mouse_pkt_t       asm_q, asm_d;
    mouse_pkt_t       pkt_q, pkt_d;
    logic             pv_q, pv_d;
    logic [7:0]       err_q, err_d;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        asm_d   = asm_q;
        pkt_d   = pkt_q;
        pv_d    = 1'b0;
        err_d   = err_q;
        if (!en) begin
            state_d = BYTE0;
            tmo_d   = '0;
        end else if (rx_done_tick) begin
            // An arriving byte always beats a coincident timeout.
            tmo_d = '0;
            unique case (state_q)
                BYTE0: begin
                    if (rx_dout[SYNC_BIT]) begin
                        asm_d   = decode_hdr(rx_dout);
                        state_d = BYTE1;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                BYTE1: begin
                    asm_d.dx[7:0] = rx_dout;
                    state_d       = BYTE2;
                end
                BYTE2: begin
                    pkt_d         = asm_q;
                    pkt_d.dy[7:0] = rx_dout;
                    pv_d          = 1'b1;
                    state_d       = BYTE0;
                end
                default: state_d = BYTE0;
            endcase
        end else if (state_q != BYTE0) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                state_d = BYTE0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BYTE0;
            tmo_q   <= '0;
            asm_q   <= '0;
            pkt_q   <= '0;
            pv_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            asm_q   <= asm_d;
            pkt_q   <= pkt_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
        end
    end

    assign pkt_valid      = pv_q;
    assign btn_l          = pkt_q.btn_l;
    assign btn_m          = pkt_q.btn_m;
    assign btn_r          = pkt_q.btn_r;
    assign dx             = pkt_q.x_ovf ? 9'd0 : pkt_q.dx;
    assign dy             = pkt_q.y_ovf ? 9'd0 : pkt_q.dy;
    assign sync_err_count = err_q;

    ps2_cursor_accum #(
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX),
        .POS_W  (POS_W),
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pv_q),
        .dx        (dx),
        .dy        (dy),
        .x_pos     (x_pos),
        .y_pos     (y_pos)
    );

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet with a shortened packet timeout.
// Expected values are hand-computed from the packet bytes.
module tb_ps2_mouse_packet;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       pkt_valid;
    logic       btn_l, btn_m, btn_r;
    logic [8:0] dx, dy;
    logic [9:0] x_pos, y_pos;
    logic [7:0] sync_err_count;

    int total = 0;
    int bad   = 0;
    int pv_cnt = 0;
    int p0;

    always #5 clk = ~clk;

    always @(posedge clk) if (pkt_valid === 1'b1) pv_cnt++;

    ps2_mouse_packet #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rx_done_tick   (rx_done_tick),
        .rx_dout        (rx_dout),
        .pkt_valid      (pkt_valid),
        .btn_l          (btn_l),
        .btn_m          (btn_m),
        .btn_r          (btn_r),
        .dx             (dx),
        .dy             (dy),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .sync_err_count (sync_err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
        send(b0);
        send(b1);
        send(b2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        en           = 1'b0;
        rx_done_tick = 1'b0;
        rx_dout      = 8'h00;
        #12;
        check("rst_pv", 32'(pkt_valid), 0);
        check("rst_x", 32'(x_pos), 320);
        check("rst_y", 32'(y_pos), 240);
        check("rst_err", 32'(sync_err_count), 0);
        check("rst_dx", 32'(dx), 0);
        check("rst_btn", 32'({btn_l, btn_m, btn_r}), 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        // basic packet, latency 1 for pkt_valid, 2 for position
        send(8'h09);
        send(8'h05);
        send(8'h03);
        check("t1_pv", 32'(pkt_valid), 1);
        check("t1_btnl", 32'(btn_l), 1);
        check("t1_dx", 32'(dx), 5);
        check("t1_dy", 32'(dy), 3);
        @(negedge clk);
        check("t1_pv_off", 32'(pkt_valid), 0);
        check("t1_x", 32'(x_pos), 325);
        check("t1_y", 32'(y_pos), 237);

        // negative deltas
        do_reset();
        pkt(8'h38, 8'hFB, 8'hFE);
        check("t2_dx", 32'(dx), 32'h1FB);
        check("t2_dy", 32'(dy), 32'h1FE);
        check("t2_btn", 32'({btn_l, btn_m, btn_r}), 0);
        check("t2_x", 32'(x_pos), 315);
        check("t2_y", 32'(y_pos), 242);

        // clamping at screen edges
        do_reset();
        pkt(8'h18, 8'h00, 8'h00);
        pkt(8'h18, 8'hC2, 8'h00);
        check("t3_x2", 32'(x_pos), 2);
        pkt(8'h18, 8'hF6, 8'h00);
        check("t3_dx", 32'(dx), 32'h1F6);
        check("t3_x0", 32'(x_pos), 0);
        pkt(8'h28, 8'h00, 8'h11);
        check("t3_ymax", 32'(y_pos), 479);
        pkt(8'h28, 8'h00, 8'hEC);
        check("t3_dy", 32'(dy), 32'h1EC);
        check("t3_yclamp", 32'(y_pos), 479);
        check("t3_xhold", 32'(x_pos), 0);

        // sync errors and saturation
        do_reset();
        send(8'h00);
        check("t4_err1", 32'(sync_err_count), 1);
        pkt(8'h0A, 8'h01, 8'h02);
        check("t4_btnr", 32'({btn_l, btn_r}), 1);
        check("t4_dx", 32'(dx), 1);
        check("t4_dy", 32'(dy), 2);
        check("t4_err_keep", 32'(sync_err_count), 1);
        for (int i = 0; i < 300; i++) send(8'(i) & 8'hF7);
        check("t4_sat", 32'(sync_err_count), 255);

        // timeout discards a partial packet
        do_reset();
        p0 = pv_cnt;
        send(8'h08);
        send(8'h01);
        repeat (TMO + 5) @(negedge clk);
        send(8'h08);
        send(8'h02);
        send(8'h03);
        repeat (2) @(negedge clk);
        check("t5_onepkt", 32'(pv_cnt - p0), 1);
        check("t5_dx", 32'(dx), 2);
        check("t5_dy", 32'(dy), 3);
        check("t5_err", 32'(sync_err_count), 0);
        send(8'h08);
        repeat (TMO - 5) @(negedge clk);
        send(8'h04);
        send(8'h06);
        @(negedge clk);
        check("t5_slow_dx", 32'(dx), 4);
        check("t5_slow_dy", 32'(dy), 6);

        // overflow zeroes the delta but buttons still update
        do_reset();
        p0 = pv_cnt;
        pkt(8'h49, 8'h7F, 8'h00);
        check("t6_ovf_pv", 32'(pv_cnt - p0), 1);
        check("t6_ovf_dx", 32'(dx), 0);
        check("t6_ovf_btn", 32'(btn_l), 1);
        check("t6_ovf_x", 32'(x_pos), 320);

        // en drop mid-packet, and bytes ignored while en is low
        p0 = pv_cnt;
        send(8'h08);
        send(8'h01);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        send(8'h03);
        en = 1'b1;
        send(8'h05);
        repeat (2) @(negedge clk);
        check("t6_en_nopkt", 32'(pv_cnt - p0), 0);
        check("t6_en_err", 32'(sync_err_count), 1);

        // async reset mid-packet
        pkt(8'h08, 8'h0A, 8'h00);
        check("t6_x330", 32'(x_pos), 330);
        send(8'h08);
        send(8'h01);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_x", 32'(x_pos), 320);
        check("t6_rst_y", 32'(y_pos), 240);
        check("t6_rst_err", 32'(sync_err_count), 0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h09);
        send(8'h05);
        send(8'h03);
        check("t6_after_pv", 32'(pkt_valid), 1);
        check("t6_after_dx", 32'(dx), 5);
        @(negedge clk);
        check("t6_after_x", 32'(x_pos), 325);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
